// File: rtl/raw2grey_pkg.sv
// Shared types and constants for the Bayer-quad binning luminance converter.
package raw2grey_pkg;

    typedef enum logic {
        MODE_SUM      = 1'b0,
        MODE_WEIGHTED = 1'b1
    } mode_e;

    // {row parity, col parity} of a site inside a 2x2 quad.
    typedef logic [1:0] bayer_phase_t;

    localparam int unsigned W_R     = 77;
    localparam int unsigned W_G     = 75;
    localparam int unsigned W_B     = 29;
    localparam int unsigned W_SHIFT = 8;

endpackage

// File: rtl/raw2grey_bin_line_ram_sp.sv
// Single-port line RAM: read-before-write with a registered read port.
module line_ram_sp #(
    parameter int DEPTH = 1280,
    parameter int WIDTH = 12,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk_i,
    input  logic             en_i,
    input  logic [AW-1:0]    addr_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // No reset on storage or read register so the array maps onto block RAM.
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            rdata_q      <= mem_q[addr_i];
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/raw2grey_bin.sv
// Bins each 2x2 Bayer quad into one greyscale pixel (plain or weighted sum),
// three-stage pipeline with halved output coordinates.
module raw2grey_bin
    import raw2grey_pkg::*;
#(
    parameter int           DATA_W      = 12,
    parameter int           OUT_W       = 8,
    parameter int           LINE_W      = 1280,
    parameter int           XY_W        = 11,
    parameter bayer_phase_t BAYER_PHASE = 2'b10
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic [DATA_W-1:0] iDATA,
    input  logic              iDVAL,
    input  logic [XY_W-1:0]   iX_Cont,
    input  logic [XY_W-1:0]   iY_Cont,
    input  logic              iMODE,
    output logic [OUT_W-1:0]  oLum,
    output logic              oDVAL,
    output logic [XY_W-2:0]   oX,
    output logic [XY_W-2:0]   oY,
    output logic              oMODE
);

    localparam int                AW       = (LINE_W > 1) ? $clog2(LINE_W) : 1;
    localparam int                WW       = DATA_W + W_SHIFT;
    localparam logic [XY_W:0]     LINE_LIM = (XY_W + 1)'(LINE_W);
    localparam logic [WW-1:0]     WR       = WW'(W_R);
    localparam logic [WW-1:0]     WG       = WW'(W_G);
    localparam logic [WW-1:0]     WB       = WW'(W_B);

    logic              accept;
    logic              quad_hit;
    logic              frame_start;
    logic [DATA_W-1:0] ram_rd;

    logic [DATA_W-1:0] left_q;
    logic              s1_vld_q;
    logic [DATA_W-1:0] s1_al_q, s1_l_q, s1_c_q;
    logic [XY_W-2:0]   s1_x_q, s1_y_q;
    logic              s2_vld_q;
    logic [OUT_W-1:0]  s2_lum_q;
    logic [XY_W-2:0]   s2_x_q, s2_y_q;
    logic              out_vld_q;
    logic [OUT_W-1:0]  lum_q;
    logic [XY_W-2:0]   ox_q, oy_q;
    mode_e             mode_q;

    logic [DATA_W-1:0] quad [4];
    logic [DATA_W-1:0] r, g1, g2, b;
    logic [DATA_W:0]   g_sum;
    logic [DATA_W+1:0] sum;
    logic [WW-1:0]     wsum;
    logic [OUT_W-1:0]  lum_d;

    assign accept      = iDVAL && ({1'b0, iX_Cont} < LINE_LIM);
    assign quad_hit    = accept && iX_Cont[0] && iY_Cont[0];
    assign frame_start = iDVAL && (iX_Cont == '0) && (iY_Cont == '0);

    line_ram_sp #(
        .DEPTH (LINE_W),
        .WIDTH (DATA_W),
        .AW    (AW)
    ) u_line_ram (
        .clk_i   (iCLK),
        .en_i    (accept),
        .addr_i  (iX_Cont[AW-1:0]),
        .wdata_i (iDATA),
        .rdata_o (ram_rd)
    );

    // The RAM read register doubles as the "above" slot of the S1 quad; the
    // value it held before this read is the above-left pixel.
    always_comb begin
        quad[0] = s1_al_q;
        quad[1] = ram_rd;
        quad[2] = s1_l_q;
        quad[3] = s1_c_q;
        r       = quad[BAYER_PHASE];
        g1      = quad[BAYER_PHASE ^ 2'b01];
        g2      = quad[BAYER_PHASE ^ 2'b10];
        b       = quad[BAYER_PHASE ^ 2'b11];
        g_sum   = {1'b0, g1} + {1'b0, g2};
        sum     = {2'b00, r} + {2'b00, g_sum[DATA_W:1]} + {2'b00, b};
        wsum    = WR * {{W_SHIFT{1'b0}}, r} + WG * {{W_SHIFT{1'b0}}, g1}
                + WG * {{W_SHIFT{1'b0}}, g2} + WB * {{W_SHIFT{1'b0}}, b};
        lum_d   = (mode_q == MODE_WEIGHTED) ? wsum[WW-1 -: OUT_W]
                                            : sum[DATA_W+1 -: OUT_W];
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            left_q    <= '0;
            s1_vld_q  <= 1'b0;
            s1_al_q   <= '0;
            s1_l_q    <= '0;
            s1_c_q    <= '0;
            s1_x_q    <= '0;
            s1_y_q    <= '0;
            s2_vld_q  <= 1'b0;
            s2_lum_q  <= '0;
            s2_x_q    <= '0;
            s2_y_q    <= '0;
            out_vld_q <= 1'b0;
            lum_q     <= '0;
            ox_q      <= '0;
            oy_q      <= '0;
            mode_q    <= MODE_SUM;
        end else begin
            if (accept) begin
                left_q <= iDATA;
            end
            if (frame_start) begin
                mode_q <= mode_e'(iMODE);
            end
            s1_vld_q <= quad_hit;
            if (quad_hit) begin
                s1_al_q <= ram_rd;
                s1_l_q  <= left_q;
                s1_c_q  <= iDATA;
                s1_x_q  <= iX_Cont[XY_W-1:1];
                s1_y_q  <= iY_Cont[XY_W-1:1];
            end
            // Stages 2 and 3 advance every clock so latency stays fixed.
            s2_vld_q  <= s1_vld_q;
            s2_lum_q  <= lum_d;
            s2_x_q    <= s1_x_q;
            s2_y_q    <= s1_y_q;
            out_vld_q <= s2_vld_q;
            lum_q     <= s2_lum_q;
            ox_q      <= s2_x_q;
            oy_q      <= s2_y_q;
        end
    end

    assign oLum  = lum_q;
    assign oDVAL = out_vld_q;
    assign oX    = ox_q;
    assign oY    = oy_q;
    assign oMODE = mode_q;

endmodule

// File: tb/tb_raw2grey_bin.sv
// Directed bench for raw2grey_bin: expected queue of {lum, x, y} plus latency stamps.
module tb_raw2grey_bin;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] data;
    logic        dval;
    logic [10:0] x, y;
    logic        mode;
    logic [7:0]  lum;
    logic        odval;
    logic [9:0]  ox, oy;
    logic        omode;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic [27:0] exp_q[$];
    int          stamp_q[$];
    logic [11:0] pix [4][8];

    raw2grey_bin #(
        .DATA_W      (12),
        .OUT_W       (8),
        .LINE_W      (8),
        .XY_W        (11),
        .BAYER_PHASE (2'b10)
    ) dut (
        .iCLK    (clk),
        .iRST    (rst),
        .iDATA   (data),
        .iDVAL   (dval),
        .iX_Cont (x),
        .iY_Cont (y),
        .iMODE   (mode),
        .oLum    (lum),
        .oDVAL   (odval),
        .oX      (ox),
        .oY      (oy),
        .oMODE   (omode)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // ---------------- scoreboard / monitor ----------------
    always @(negedge clk) begin
        logic [27:0] e;
        if (!rst && dval && x[0] && y[0] && (x < 11'd8))
            stamp_q.push_back(cyc);
        if (odval) begin
            if (exp_q.size() == 0) begin
                check_eq("spurious_odval", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_eq("lum", {24'd0, lum}, {24'd0, e[27:20]});
                check_eq("ox",  {22'd0, ox},  {22'd0, e[19:10]});
                check_eq("oy",  {22'd0, oy},  {22'd0, e[9:0]});
            end
            if (stamp_q.size() == 0)
                check_eq("latency_stamp", 32'd0, 32'd1);
            else
                check_eq("latency", cyc - stamp_q.pop_front(), 32'd3);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive_pix(input int px, input int py, input logic [11:0] d, input logic m);
        @(posedge clk);
        #1;
        dval = 1'b1;
        x    = px[10:0];
        y    = py[10:0];
        data = d;
        mode = m;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            dval = 1'b0;
        end
    endtask

    task automatic send_frame(input int w, input int h, input logic m0, input logic m1, input int gap);
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                if (gap > 0) begin
                    int k;
                    k = $urandom_range(0, gap);
                    if (k > 0) idle(k);
                end
                drive_pix(c, r, pix[r][c], (r == 0 && c == 0) ? m0 : m1);
            end
        end
        idle(1);
    endtask

    task automatic push_exp(input int qx, input int qy, input logic [7:0] l);
        exp_q.push_back({l, qx[9:0], qy[9:0]});
    endtask

    task automatic push_frame(input int w, input int h, input logic [7:0] l);
        for (int qy = 0; qy < h / 2; qy++)
            for (int qx = 0; qx < w / 2; qx++)
                push_exp(qx, qy, l);
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        check_eq(tag, exp_q.size(), 32'd0);
        exp_q.delete();
        stamp_q.delete();
    endtask

    task automatic fill_uniform(input logic [11:0] v);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 8; c++)
                pix[r][c] = v;
    endtask

    // Even rows: G at even columns, B at odd; odd rows: R at even, G at odd.
    task automatic fill_bayer(input logic [11:0] rv, input logic [11:0] gv, input logic [11:0] bv);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 8; c++)
                pix[r][c] = (r % 2 == 0) ? ((c % 2 == 0) ? gv : bv)
                                         : ((c % 2 == 0) ? rv : gv);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst  = 1'b1;
        dval = 1'b0;
        x    = '0;
        y    = '0;
        data = '0;
        mode = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_lum",   {24'd0, lum}, 32'd0);
        check_eq("rst_dval",  {31'd0, odval}, 32'd0);
        check_eq("rst_ox",    {22'd0, ox}, 32'd0);
        check_eq("rst_oy",    {22'd0, oy}, 32'd0);
        check_eq("rst_mode",  {31'd0, omode}, 32'd0);
        rst = 1'b0;
        idle(2);

        // Uniform full-scale, sum then weighted.
        fill_uniform(12'd4095);
        push_frame(8, 4, 8'd191);
        send_frame(8, 4, 1'b0, 1'b0, 0);
        wait_drain("t1_drain");
        check_eq("t1_mode", {31'd0, omode}, 32'd0);

        push_frame(8, 4, 8'd255);
        send_frame(8, 4, 1'b1, 1'b1, 0);
        wait_drain("t2_drain");
        check_eq("t2_mode", {31'd0, omode}, 32'd1);

        // R=1000, G=2000, B=500 quads.
        fill_bayer(12'd1000, 12'd2000, 12'd500);
        push_frame(8, 4, 8'd54);
        send_frame(8, 4, 1'b0, 1'b0, 0);
        wait_drain("t3s_drain");
        push_frame(8, 4, 8'd95);
        send_frame(8, 4, 1'b1, 1'b1, 0);
        wait_drain("t3w_drain");

        // Same stream with random input gaps.
        push_frame(8, 4, 8'd54);
        send_frame(8, 4, 1'b0, 1'b0, 3);
        wait_drain("t4s_drain");
        push_frame(8, 4, 8'd95);
        send_frame(8, 4, 1'b1, 1'b1, 3);
        wait_drain("t4w_drain");

        // Distinct pixels per site on a 4x2 frame.
        for (int c = 0; c < 4; c++) begin
            pix[0][c] = 12'(100 * (c + 1));
            pix[1][c] = 12'(100 * (c + 5));
        end
        push_exp(0, 0, 8'd16);
        push_exp(1, 0, 8'd25);
        send_frame(4, 2, 1'b0, 1'b0, 0);
        wait_drain("t7s_drain");
        push_exp(0, 0, 8'd23);
        push_exp(1, 0, 8'd36);
        send_frame(4, 2, 1'b1, 1'b1, 0);
        wait_drain("t7w_drain");

        // Mode toggled mid-frame takes effect only at the next frame start.
        fill_uniform(12'd4095);
        push_frame(8, 4, 8'd191);
        send_frame(8, 4, 1'b0, 1'b1, 1);
        wait_drain("t5a_drain");
        check_eq("t5a_mode", {31'd0, omode}, 32'd0);
        push_frame(8, 4, 8'd255);
        send_frame(8, 4, 1'b1, 1'b0, 0);
        wait_drain("t5b_drain");
        check_eq("t5b_mode", {31'd0, omode}, 32'd1);

        // Reset while a quad sits in the arithmetic stage.
        fill_bayer(12'd1000, 12'd2000, 12'd500);
        for (int c = 0; c < 8; c++) drive_pix(c, 0, pix[0][c], 1'b0);
        drive_pix(0, 1, pix[1][0], 1'b0);
        drive_pix(1, 1, pix[1][1], 1'b0);
        idle(2);
        rst = 1'b1;
        #1;
        check_eq("t6_dval_in_rst", {31'd0, odval}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check_eq("t6_dval_hold", {31'd0, odval}, 32'd0);
        check_eq("t6_mode_rst",  {31'd0, omode}, 32'd0);
        rst = 1'b0;
        stamp_q.delete();
        idle(5);
        check_eq("t6_no_output", exp_q.size(), 32'd0);
        push_frame(8, 4, 8'd54);
        send_frame(8, 4, 1'b0, 1'b0, 0);
        wait_drain("t6_drain");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
